// File: rtl/oneshot_pkg.sv
// oneshot_pkg: shared types and helpers for the debounced one-shot bank.
//   os_state_t : per-channel FSM state encoding
//   max3       : maximum of three unsigned values
//   cnt_width  : width of the per-channel counter, sized for the longest interval
package oneshot_pkg;

  typedef enum logic [2:0] {
    OS_IDLE    = 3'd0,
    OS_ARM     = 3'd1,
    OS_FIRE    = 3'd2,
    OS_HOLD    = 3'd3,
    OS_RELEASE = 3'd4
  } os_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One counter serves debounce, repeat delay and repeat period; size it for the largest.
  function automatic int unsigned cnt_width(input int unsigned db, input int unsigned delay,
                                            input int unsigned period);
    return $clog2(max3(db, delay, period) + 1);
  endfunction

endpackage

// File: rtl/oneshot_channel.sv
// oneshot_channel: one debounced one-shot pulse generator with optional auto-repeat.
//   clk       : system clock, all state on rising edge
//   rst       : asynchronous active-high reset
//   e         : raw level input, asynchronous to clk (bouncy)
//   repeat_en : auto-repeat enable, synchronous to clk
//   z         : single-cycle strobe per accepted press or repeat
//   held      : high from the accepted press until the debounced release completes
module oneshot_channel
  import oneshot_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned RPT_DELAY  = 8,
  parameter int unsigned RPT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic e,
  input  logic repeat_en,
  output logic z,
  output logic held
);

  localparam int unsigned CntW = cnt_width(DB_CYCLES, RPT_DELAY, RPT_PERIOD);

  // Terminal counts. HOLD spends RPT_x-1 cycles before FIRE, and FIRE itself is one
  // cycle, so pulse starts are spaced exactly RPT_x apart.
  localparam logic [CntW-1:0] DbLast     = CntW'(DB_CYCLES - 1);
  localparam logic [CntW-1:0] DelayLast  = CntW'(RPT_DELAY - 2);
  localparam logic [CntW-1:0] PeriodLast = CntW'(RPT_PERIOD - 2);

  logic            sync_q;
  logic            e_s;
  os_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rph_q, rph_d;
  logic [CntW-1:0] hold_last;

  // Two-flop synchroniser; e_s is the only version of e the FSM ever sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      e_s    <= 1'b0;
    end else begin
      sync_q <= e;
      e_s    <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OS_IDLE;
      cnt_q   <= '0;
      rph_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rph_q   <= rph_d;
    end
  end

  // First repeat waits the long delay; after that the short period applies.
  assign hold_last = rph_q ? PeriodLast : DelayLast;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rph_d   = rph_q;
    unique case (state_q)
      OS_IDLE: begin
        if (e_s) begin
          state_d = OS_ARM;
          cnt_d   = '0;
        end
      end
      OS_ARM: begin
        if (!e_s) begin
          state_d = OS_IDLE;
        end else if (cnt_q == DbLast) begin
          state_d = OS_FIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OS_FIRE: begin
        state_d = OS_HOLD;
        cnt_d   = '0;
      end
      OS_HOLD: begin
        if (!e_s) begin
          state_d = OS_RELEASE;
          cnt_d   = '0;
          rph_d   = 1'b0;
        end else if (!repeat_en) begin
          // Keeping the counter cleared means re-enabling repeat restarts the long delay.
          cnt_d = '0;
          rph_d = 1'b0;
        end else if (cnt_q == hold_last) begin
          state_d = OS_FIRE;
          rph_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OS_RELEASE: begin
        if (e_s) begin
          // Release bounce: back to HOLD without a new pulse.
          state_d = OS_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d = OS_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = OS_IDLE;
        cnt_d   = '0;
        rph_d   = 1'b0;
      end
    endcase
  end

  // Moore outputs from registered state only, so they drop as soon as rst asserts.
  assign z    = (state_q == OS_FIRE);
  assign held = (state_q == OS_FIRE) || (state_q == OS_HOLD) || (state_q == OS_RELEASE);

endmodule

// File: rtl/oneshot_bank.sv
// oneshot_bank: N_CH independent debounced one-shot generators sharing a repeat enable.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   e         : raw level inputs, one per channel, asynchronous to clk
//   repeat_en : global auto-repeat enable, synchronous to clk
//   z         : per-channel single-cycle strobes
//   held      : per-channel press-held status
module oneshot_bank
  import oneshot_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned RPT_DELAY  = 8,
  parameter int unsigned RPT_PERIOD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] e,
  input  logic            repeat_en,
  output logic [N_CH-1:0] z,
  output logic [N_CH-1:0] held
);

  if (N_CH < 1) begin : gen_bad_n_ch
    $error("oneshot_bank: N_CH must be >= 1");
  end
  if (DB_CYCLES < 1) begin : gen_bad_db
    $error("oneshot_bank: DB_CYCLES must be >= 1");
  end
  if (RPT_DELAY < 2) begin : gen_bad_delay
    $error("oneshot_bank: RPT_DELAY must be >= 2");
  end
  if (RPT_PERIOD < 2) begin : gen_bad_period
    $error("oneshot_bank: RPT_PERIOD must be >= 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    oneshot_channel #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .e        (e[i]),
      .repeat_en(repeat_en),
      .z        (z[i]),
      .held     (held[i])
    );
  end

endmodule

// File: tb/tb_oneshot_bank.sv
module tb_oneshot_bank;

  localparam int unsigned NCh = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCh-1:0] e;
  logic           repeat_en;
  logic [NCh-1:0] z;
  logic [NCh-1:0] held;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  typedef struct {
    int unsigned    at;
    logic [NCh-1:0] bits;
  } pulse_t;

  pulse_t exp_q[$];

  oneshot_bank #(
    .N_CH      (4),
    .DB_CYCLES (4),
    .RPT_DELAY (8),
    .RPT_PERIOD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .e        (e),
    .repeat_en(repeat_en),
    .z        (z),
    .held     (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int unsigned at, input logic [NCh-1:0] bits);
    pulse_t p;
    p.at   = at;
    p.bits = bits;
    exp_q.push_back(p);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every observed pulse must match the next expected one in time and lanes.
  always @(negedge clk) begin : monitor
    pulse_t p;
    if (!rst && z != '0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pulse: got z=%b at cycle %0d, required no pulse", z, cyc);
      end else begin
        p = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(p.at));
        check("pulse_bits", 32'(z), 32'(p.bits));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int unsigned c;
    int unsigned r;
    logic acc;
    rst = 1'b1;
    e = '0;
    repeat_en = 1'b0;
    step(2);
    check("reset_z", 32'(z), 0);
    check("reset_held", 32'(held), 0);
    rst = 1'b0;
    step(3);

    // Single press, no repeat: one pulse 7 edges after the first sample.
    c = cyc;
    e[0] = 1'b1;
    push(c + 7, 4'b0001);
    step(6);
    check("t1_held_before", 32'(held[0]), 0);
    step(1);
    check("t1_held_rise", 32'(held[0]), 1);
    step(13);
    e[0] = 1'b0;
    step(6);
    check("t1_held_before_fall", 32'(held[0]), 1);
    step(1);
    check("t1_held_fall", 32'(held[0]), 0);
    step(3);

    // Glitch of 4 cycles is rejected.
    e[1] = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      acc |= held[1];
    end
    e[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      acc |= held[1];
    end
    check("glitch4_held", 32'(acc), 0);

    // 5 cycles is just enough.
    c = cyc;
    e[1] = 1'b1;
    push(c + 7, 4'b0010);
    step(5);
    e[1] = 1'b0;
    step(14);
    check("glitch5_held_cleared", 32'(held[1]), 0);

    // Auto-repeat: t0, t0+8, then every 4 while held.
    repeat_en = 1'b1;
    c = cyc;
    e[2] = 1'b1;
    push(c + 7, 4'b0100);
    push(c + 15, 4'b0100);
    push(c + 19, 4'b0100);
    push(c + 23, 4'b0100);
    push(c + 27, 4'b0100);
    push(c + 31, 4'b0100);
    step(30);
    e[2] = 1'b0;
    step(6);
    check("rpt_held_before_fall", 32'(held[2]), 1);
    step(1);
    check("rpt_held_fall", 32'(held[2]), 0);
    repeat_en = 1'b0;
    step(4);

    // Release bounce: short low during HOLD gives no pulse and keeps held.
    c = cyc;
    e[3] = 1'b1;
    push(c + 7, 4'b1000);
    step(12);
    e[3] = 1'b0;
    step(2);
    e[3] = 1'b1;
    acc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      acc &= held[3];
    end
    check("bounce_held_kept", 32'(acc), 1);
    step(1);
    e[3] = 1'b0;
    step(6);
    check("bounce_held_before_fall", 32'(held[3]), 1);
    step(1);
    check("bounce_held_fall", 32'(held[3]), 0);
    step(3);

    // Async reset in the FIRE cycle of channel 0.
    c = cyc;
    e[0] = 1'b1;
    step(6);
    @(posedge clk);
    #2;
    check("rst_fire_seen", 32'(z[0]), 1);
    rst = 1'b1;
    #1;
    check("rst_z_drop", 32'(z), 0);
    check("rst_held_drop", 32'(held), 0);
    step(2);
    rst = 1'b0;
    r = cyc;
    push(r + 7, 4'b0001);
    step(12);
    e[0] = 1'b0;
    step(10);

    // Concurrent presses on 0 and 3 pulse together.
    c = cyc;
    e[0] = 1'b1;
    e[3] = 1'b1;
    push(c + 7, 4'b1001);
    step(7);
    check("conc_held", 32'(held), 32'(4'b1001));
    step(3);
    e = '0;
    step(10);
    check("conc_held_cleared", 32'(held), 0);

    step(5);
    check("all_pulses_seen", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
